block_retrieve_buffer: RTL
==========================

Name: block_retrieve_buffer

Overview:
- Ping-pong 64-coefficient block store between the inverse quantiser and the IDCT.
- Accepts sparse, random-address 12-bit coefficient writes from the dequantiser and commits each finished block.
- Streams committed blocks to the IDCT in fixed index order with a valid/ready handshake.
- Each bank is cleared to zero as it drains, so unwritten coefficients always read as 0.

Parameters:
- DATA_WIDTH, 12, coefficient width.
- CLEAR_CYCLES, 64, length of the post-reset clear sweep. Must be 64.

Ports:
- clock  input  1  system clock
- resetn  input  1  reset; active-low, synchronous to clock
- Block_Retrieve_Ready_O  output  1  a bank is free to fill
- Block_Retrieve_Write_En_I  input  1  coefficient write strobe
- Block_Retrieve_Address_I  input  6  coefficient index 0..63
- Block_Retrieve_Data_I  input  DATA_WIDTH  dequantised coefficient
- Block_Retrieve_Waiting_I  input  1  dequantiser done/idle; a rising edge commits the fill bank
- IDCT_Valid_O  output  1  IDCT_Data_O holds a coefficient
- IDCT_Ready_I  input  1  IDCT accepts the coefficient
- IDCT_Data_O  output  DATA_WIDTH  coefficient
- IDCT_Index_O  output  6  coefficient index of IDCT_Data_O
- IDCT_Last_O  output  1  index 63 of the current block
- Overflow_O  output  1  sticky: write attempted while Ready_O low

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-low: all state is sampled on the posedge of clock when resetn=0.
- Reset values:
  - Ready_O=0, IDCT_Valid_O=0, IDCT_Data_O=0, IDCT_Index_O=0, IDCT_Last_O=0, Overflow_O=0.
  - Both banks marked EMPTY; fill pointer = bank 0; drain pointer = bank 0.
- Clear sweep:
  - After resetn returns high, a 64-cycle sweep writes 0 to address n of both banks on sweep cycle n.
  - Ready_O rises on the cycle after the sweep ends, i.e. cycle 65 after reset release.
  - Asserting reset mid-operation discards all data and restarts the sweep.
- Bank states: EMPTY, FILLING, FULL, DRAINING.
  - The fill bank goes EMPTY→FILLING on its first write.
  - Commit: Waiting_I is registered; commit = Waiting_I & ~Waiting_q. On commit the fill bank becomes FULL and the fill pointer toggles.
  - A commit on an EMPTY fill bank (skipped or all-zero block) also becomes FULL and streams 64 zeros.
- Ready_O:
  - Registered. It is 1 when the bank under the fill pointer is EMPTY or FILLING.
  - It drops on the cycle after a commit if the other bank is not EMPTY.
- Writes:
  - A write with Ready_O=1 stores Data at Address in the fill bank; last write wins.
  - A write with Ready_O=0 is dropped and sets Overflow_O; Overflow_O clears only on reset.
- Drain FSM states: RD_IDLE, RD_STREAM.
  - RD_IDLE→RD_STREAM when the drain-pointer bank is FULL; that bank becomes DRAINING.
  - Read RAM latency is 1 cycle. First IDCT_Valid_O asserts 2 cycles after commit when the drain side is idle.
  - Data/Index/Last hold stable while Valid_O=1 and Ready_I=0.
  - Each accepted beat (Valid_O & Ready_I) writes 0 to the read address and advances the index.
  - Accepting index 63 marks the bank EMPTY and toggles the drain pointer.
  - If the other bank is already FULL, Valid_O stays high with no bubble: the next block's index 0 is presented the cycle after index 63 is accepted. Otherwise the FSM returns to RD_IDLE.
  - Sustained throughput: 1 coefficient per clock.
- Simultaneous events:
  - Commit in the same cycle as drain-complete of the other bank: both take effect. Ready_O stays 1, since the new fill bank is the just-emptied bank.
  - Write in the same cycle as commit: the write lands in the committing bank.
  - Commit while Ready_O=0: ignored; sets Overflow_O.
- Index order: raster, Index = counter[5:0].

Optional Feature:
- Macro: BLOCK_RETRIEVE_TRANSPOSE_EN.
- Defined: drain order is column-major. The counter c maps to Index = {c[2:0], c[5:3]}; Last still marks the 64th beat (Index 63).
- Clear-on-read follows the transposed address.
- Undefined: raster order only; no transpose logic is synthesised.

Test Plan:
- Reset release → Ready_O=0 for 64 cycles, then 1 at cycle 65; all outputs 0 meanwhile.
- Write addr 0=12'h7FF and addr 63=12'h801, then Waiting_I 0→1, Ready_I=1 → 64 beats: index 0 = 7FF, index 63 = 801 with Last=1, all others 0; first Valid 2 cycles after commit.
- Commit two blocks back-to-back with Ready_I=1 → 128 consecutive valid beats with no bubble. Ready_O low after the second commit until the first block's index 63 is accepted.
- Ready_I toggled 1/0 every cycle → every coefficient appears exactly once; Data/Index stable during stalls.
- Fill bank A, commit, refill the same addresses in the next pass with only addr 5 written → second block reads 0 everywhere except addr 5, proving clear-on-read.
- Both banks FULL and drain stalled, then write 12'h123 → write dropped, Overflow_O=1 and stays 1 until reset. With BLOCK_RETRIEVE_TRANSPOSE_EN defined, beat 1 has Index=8.

Source files
------------

// File: rtl/block_retrieve_buffer.sv
// Ping-pong 64-coefficient block store between the inverse quantiser and the IDCT.
// Optional column-major drain order is selected with BLOCK_RETRIEVE_TRANSPOSE_EN.
module block_retrieve_buffer #(
    parameter int DATA_WIDTH   = 12,
    parameter int CLEAR_CYCLES = 64
) (
    input  logic                  clock,
    input  logic                  resetn,
    output logic                  Block_Retrieve_Ready_O,
    input  logic                  Block_Retrieve_Write_En_I,
    input  logic [5:0]            Block_Retrieve_Address_I,
    input  logic [DATA_WIDTH-1:0] Block_Retrieve_Data_I,
    input  logic                  Block_Retrieve_Waiting_I,
    output logic                  IDCT_Valid_O,
    input  logic                  IDCT_Ready_I,
    output logic [DATA_WIDTH-1:0] IDCT_Data_O,
    output logic [5:0]            IDCT_Index_O,
    output logic                  IDCT_Last_O,
    output logic                  Overflow_O
);

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_STREAM
    } rd_state_t;

    // Handshake: a beat transfers on every clock edge where IDCT_Valid_O and
    // IDCT_Ready_I are both high; while Valid is high and Ready low, Data,
    // Index and Last are held unchanged and Valid does not drop.

    function automatic logic [5:0] drain_addr(input logic [5:0] c);
`ifdef BLOCK_RETRIEVE_TRANSPOSE_EN
        return {c[2:0], c[5:3]};
`else
        return c;
`endif
    endfunction

    logic [DATA_WIDTH-1:0] mem0 [64];
    logic [DATA_WIDTH-1:0] mem1 [64];

    bank_state_t           bank_q [2];
    bank_state_t           bank_d [2];
    rd_state_t             rd_state_q, rd_state_d;
    logic                  clearing_q;
    logic [5:0]            clear_cnt_q;
    logic                  fill_ptr_q, fill_ptr_d;
    logic                  drain_ptr_q, drain_ptr_d;
    logic                  other_ptr;
    logic                  waiting_q;
    logic                  ready_q, ready_d;
    logic                  overflow_q;
    logic [6:0]            rd_cnt_q, rd_cnt_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [5:0]            index_q;
    logic                  last_q;

    logic                  commit, wr_ok, commit_ok, accept, overflow_set;
    logic                  load, load_bank, clr_en;
    logic [5:0]            load_cnt, load_addr;
    logic                  we0, we1;
    logic [5:0]            addr0, addr1;
    logic [DATA_WIDTH-1:0] wdata0, wdata1;

    assign commit       = Block_Retrieve_Waiting_I & ~waiting_q;
    assign wr_ok        = Block_Retrieve_Write_En_I & ready_q;
    assign commit_ok    = commit & ready_q;
    assign overflow_set = (Block_Retrieve_Write_En_I | commit) & ~ready_q;
    assign accept       = valid_q & IDCT_Ready_I;
    assign other_ptr    = ~drain_ptr_q;
    assign load_addr    = drain_addr(load_cnt);

    always_comb begin
        bank_d      = bank_q;
        fill_ptr_d  = fill_ptr_q;
        drain_ptr_d = drain_ptr_q;
        rd_state_d  = rd_state_q;
        rd_cnt_d    = rd_cnt_q;
        valid_d     = valid_q;
        load        = 1'b0;
        load_bank   = drain_ptr_q;
        load_cnt    = rd_cnt_q[5:0];
        clr_en      = 1'b0;

        if (wr_ok && bank_q[fill_ptr_q] == BANK_EMPTY) begin
            bank_d[fill_ptr_q] = BANK_FILLING;
        end
        if (commit_ok) begin
            bank_d[fill_ptr_q] = BANK_FULL;
            fill_ptr_d         = ~fill_ptr_q;
        end

        case (rd_state_q)
            RD_IDLE: begin
                if (bank_q[drain_ptr_q] == BANK_FULL) begin
                    bank_d[drain_ptr_q] = BANK_DRAINING;
                    rd_state_d          = RD_STREAM;
                    rd_cnt_d            = '0;
                end
            end
            RD_STREAM: begin
                clr_en = accept;
                if (accept && last_q) begin
                    bank_d[drain_ptr_q] = BANK_EMPTY;
                    drain_ptr_d         = other_ptr;
                    // Chain straight into the other bank so the stream has no bubble.
                    if (bank_q[other_ptr] == BANK_FULL) begin
                        bank_d[other_ptr] = BANK_DRAINING;
                        load              = 1'b1;
                        load_bank         = other_ptr;
                        load_cnt          = '0;
                        rd_cnt_d          = 7'd1;
                    end else begin
                        rd_state_d = RD_IDLE;
                        valid_d    = 1'b0;
                    end
                end else if ((!valid_q || accept) && !rd_cnt_q[6]) begin
                    load     = 1'b1;
                    rd_cnt_d = rd_cnt_q + 7'd1;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase

        if (load) begin
            valid_d = 1'b1;
        end

        ready_d = !clearing_q &&
                  (bank_d[fill_ptr_d] == BANK_EMPTY || bank_d[fill_ptr_d] == BANK_FILLING);
    end

    // Bank write ports: the sweep owns both banks; otherwise fill and drain never share a bank.
    always_comb begin
        we0    = 1'b0;
        addr0  = index_q;
        wdata0 = '0;
        if (clearing_q) begin
            we0   = 1'b1;
            addr0 = clear_cnt_q;
        end else if (wr_ok && !fill_ptr_q) begin
            we0    = 1'b1;
            addr0  = Block_Retrieve_Address_I;
            wdata0 = Block_Retrieve_Data_I;
        end else if (clr_en && !drain_ptr_q) begin
            we0 = 1'b1;
        end

        we1    = 1'b0;
        addr1  = index_q;
        wdata1 = '0;
        if (clearing_q) begin
            we1   = 1'b1;
            addr1 = clear_cnt_q;
        end else if (wr_ok && fill_ptr_q) begin
            we1    = 1'b1;
            addr1  = Block_Retrieve_Address_I;
            wdata1 = Block_Retrieve_Data_I;
        end else if (clr_en && drain_ptr_q) begin
            we1 = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (resetn && we0) mem0[addr0] <= wdata0;
        if (resetn && we1) mem1[addr1] <= wdata1;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            bank_q[0]   <= BANK_EMPTY;
            bank_q[1]   <= BANK_EMPTY;
            rd_state_q  <= RD_IDLE;
            clearing_q  <= 1'b1;
            clear_cnt_q <= '0;
            fill_ptr_q  <= 1'b0;
            drain_ptr_q <= 1'b0;
            // An idle dequantiser held across reset must not look like a commit.
            waiting_q   <= 1'b1;
            ready_q     <= 1'b0;
            overflow_q  <= 1'b0;
            rd_cnt_q    <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            index_q     <= '0;
            last_q      <= 1'b0;
        end else begin
            if (clearing_q) begin
                clear_cnt_q <= clear_cnt_q + 6'd1;
                if (clear_cnt_q == 6'(CLEAR_CYCLES - 1)) clearing_q <= 1'b0;
            end
            bank_q      <= bank_d;
            rd_state_q  <= rd_state_d;
            fill_ptr_q  <= fill_ptr_d;
            drain_ptr_q <= drain_ptr_d;
            waiting_q   <= Block_Retrieve_Waiting_I;
            ready_q     <= ready_d;
            rd_cnt_q    <= rd_cnt_d;
            valid_q     <= valid_d;
            if (overflow_set) overflow_q <= 1'b1;
            if (load) begin
                data_q  <= load_bank ? mem1[load_addr] : mem0[load_addr];
                index_q <= load_addr;
                last_q  <= (load_cnt == 6'd63);
            end
        end
    end

    assign Block_Retrieve_Ready_O = ready_q;
    assign IDCT_Valid_O           = valid_q;
    assign IDCT_Data_O            = data_q;
    assign IDCT_Index_O           = index_q;
    assign IDCT_Last_O            = last_q;
    assign Overflow_O             = overflow_q;

endmodule
